// File: rtl/demux_stream_if.sv
// demux_stream_if: bundles the upstream stream and the two downstream streams
// of demux_stream. The slave modport is the demultiplexer's view; the master
// modport is the view of the surrounding producer and consumers.
//
// Handshake: a word moves across a link on a rising clock edge where both
// valid and ready are 1. A producer that raises valid holds its data
// (and in_sel) stable until that edge. in_ready may depend on in_sel but
// never on in_valid, and it only looks at the slot that in_sel selects.
interface demux_stream_if #(
  parameter int LEN_DATA = 256
);
  logic [LEN_DATA-1:0] in_data;
  logic                in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [LEN_DATA-1:0] a_data;
  logic                a_valid;
  logic                a_ready;
  logic [LEN_DATA-1:0] b_data;
  logic                b_valid;
  logic                b_ready;

  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
  );

  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
  );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: 1-to-2 registered stream demultiplexer. Each accepted word is
// steered by in_sel into a one-entry output slot (A for sel=0, B for sel=1).
// Each slot is an EMPTY/FULL state machine; its state is exported directly as
// x_valid, so slot state is always visible on the ports.
// Optional feature macro: DEMUX_STREAM_CNT_EN adds cnt_a / cnt_b, which count
// completed drains of each output and wrap at 2^CNT_W.
module demux_stream #(
  parameter int LEN_DATA = 256,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_stream_if.slave        bus
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0]     cnt_a,
  output logic [CNT_W-1:0]     cnt_b
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e         a_state, a_state_nxt;
  slot_state_e         b_state, b_state_nxt;
  logic [LEN_DATA-1:0] a_data_q, b_data_q;
  logic                a_valid, b_valid;
  logic                a_free, b_free;
  logic                acc_a, acc_b;
  logic                drain_a, drain_b;

  assign a_valid = (a_state == FULL);
  assign b_valid = (b_state == FULL);

  // A slot can take a word when it is empty or is being drained this cycle.
  assign a_free  = ~a_valid | bus.a_ready;
  assign b_free  = ~b_valid | bus.b_ready;

  assign bus.in_ready = bus.in_sel ? b_free : a_free;

  assign acc_a   = bus.in_valid & a_free & ~bus.in_sel;
  assign acc_b   = bus.in_valid & b_free &  bus.in_sel;
  assign drain_a = a_valid & bus.a_ready;
  assign drain_b = b_valid & bus.b_ready;

  // Next-state logic: a load wins over a drain, so drain+load keeps the slot FULL.
  always_comb begin
    a_state_nxt = a_state;
    b_state_nxt = b_state;
    if (acc_a)        a_state_nxt = FULL;
    else if (drain_a) a_state_nxt = EMPTY;
    if (acc_b)        b_state_nxt = FULL;
    else if (drain_b) b_state_nxt = EMPTY;
  end

  // Slot state registers; reset empties both slots immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state <= EMPTY;
      b_state <= EMPTY;
    end else begin
      a_state <= a_state_nxt;
      b_state <= b_state_nxt;
    end
  end

  // Slot data registers: load on accept only, otherwise keep the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (acc_a) a_data_q <= bus.in_data;
      if (acc_b) b_data_q <= bus.in_data;
    end
  end

  assign bus.a_valid = a_valid;
  assign bus.b_valid = b_valid;
  assign bus.a_data  = a_data_q;
  assign bus.b_data  = b_data_q;

`ifdef DEMUX_STREAM_CNT_EN
  // Transfer counters: one increment per completed drain, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (drain_a) cnt_a <= cnt_a + 1'b1;
      if (drain_b) cnt_b <= cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream. Directed table of
// single-cycle vectors, hand-written multi-cycle sequences (streaming, reset,
// counters when DEMUX_STREAM_CNT_EN is defined) and a randomized phase
// checked against a queue-based model of the two one-entry output buffers.
module tb_demux_stream;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  demux_stream_if #(.LEN_DATA(W)) bus ();

`ifdef DEMUX_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_a, cnt_b;
`endif

  demux_stream #(.LEN_DATA(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave)
`ifdef DEMUX_STREAM_CNT_EN
    ,
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
`endif
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected contents of each one-entry output buffer
  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sel, input logic vld, input logic [W-1:0] d,
                       input logic ar, input logic br);
    bus.in_sel   = sel;
    bus.in_valid = vld;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         sel;
    logic         vld;
    logic [W-1:0] d;
    logic         ar;
    logic         br;
    logic         e_rdy;
    logic         e_av;
    logic [W-1:0] e_ad;
    logic         e_bv;
    logic [W-1:0] e_bd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Directed vectors, applied from the reset state. e_rdy is checked before
    // the edge; the slot expectations describe the state after the edge.
    vecs[0] = '{1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 32'h22};
    vecs[5] = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 32'h22};
    vecs[6] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 32'h22};
    vecs[7] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 32'h44};
    vecs[8] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 1'b0, 32'h44};

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #12;
    chk("reset_a_valid", {31'b0, bus.a_valid}, 32'd0);
    chk("reset_b_valid", {31'b0, bus.b_valid}, 32'd0);
    chk("reset_a_data", bus.a_data, 32'd0);
    chk("reset_b_data", bus.b_data, 32'd0);
`ifdef DEMUX_STREAM_CNT_EN
    chk("reset_cnt_a", {28'b0, cnt_a}, 32'd0);
    chk("reset_cnt_b", {28'b0, cnt_b}, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].sel, vecs[i].vld, vecs[i].d, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, vecs[i].e_rdy});
      tick();
      chk($sformatf("vec%0d_a_valid", i), {31'b0, bus.a_valid}, {31'b0, vecs[i].e_av});
      chk($sformatf("vec%0d_a_data", i), bus.a_data, vecs[i].e_ad);
      chk($sformatf("vec%0d_b_valid", i), {31'b0, bus.b_valid}, {31'b0, vecs[i].e_bv});
      chk($sformatf("vec%0d_b_data", i), bus.b_data, vecs[i].e_bd);
    end

    // Streaming: 8 back-to-back words to A with the consumer always ready
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, W'(i), 1'b1, 1'b0);
      #1;
      chk($sformatf("stream%0d_in_ready", i), {31'b0, bus.in_ready}, 32'd1);
      tick();
      chk($sformatf("stream%0d_a_valid", i), {31'b0, bus.a_valid}, 32'd1);
      chk($sformatf("stream%0d_a_data", i), bus.a_data, W'(i));
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    chk("stream_end_a_valid", {31'b0, bus.a_valid}, 32'd0);
    chk("stream_end_b_valid", {31'b0, bus.b_valid}, 32'd0);

    // Randomized phase against the buffer model
    begin
      logic         r_sel, r_vld, r_ar, r_br, m_rdy;
      logic [W-1:0] r_d;
      logic         hold;
      hold = 1'b0;
      r_sel = 1'b0;
      r_d = '0;
      for (int c = 0; c < 600; c++) begin
        if (!hold) begin
          r_vld = ($urandom_range(0, 3) != 0);
          r_sel = 1'($urandom_range(0, 1));
          r_d   = $urandom;
        end else begin
          r_vld = 1'b1;
        end
        r_ar = ($urandom_range(0, 2) != 0);
        r_br = ($urandom_range(0, 3) == 0);
        drive(r_sel, r_vld, r_d, r_ar, r_br);
        #1;
        m_rdy = r_sel ? (exp_qb.size() == 0 || r_br) : (exp_qa.size() == 0 || r_ar);
        chk("rand_in_ready", {31'b0, bus.in_ready}, {31'b0, m_rdy});
        chk("rand_a_valid", {31'b0, bus.a_valid}, {31'b0, exp_qa.size() != 0});
        chk("rand_b_valid", {31'b0, bus.b_valid}, {31'b0, exp_qb.size() != 0});
        if (exp_qa.size() != 0) chk("rand_a_data", bus.a_data, exp_qa[0]);
        if (exp_qb.size() != 0) chk("rand_b_data", bus.b_data, exp_qb[0]);
        @(posedge clk);
        if (exp_qa.size() != 0 && r_ar) void'(exp_qa.pop_front());
        if (exp_qb.size() != 0 && r_br) void'(exp_qb.pop_front());
        if (r_vld && m_rdy) begin
          if (r_sel) exp_qb.push_back(r_d);
          else       exp_qa.push_back(r_d);
        end
        hold = r_vld && !m_rdy;
        #1;
      end
    end

    // Reset mid-run with both slots full
    drive(1'b0, 1'b1, 32'h5A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h6B, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("prerst_a_valid", {31'b0, bus.a_valid}, 32'd1);
    chk("prerst_b_valid", {31'b0, bus.b_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_a_valid", {31'b0, bus.a_valid}, 32'd0);
    chk("midrst_b_valid", {31'b0, bus.b_valid}, 32'd0);
    chk("midrst_a_data", bus.a_data, 32'd0);
    chk("midrst_b_data", bus.b_data, 32'd0);
`ifdef DEMUX_STREAM_CNT_EN
    chk("midrst_cnt_a", {28'b0, cnt_a}, 32'd0);
    chk("midrst_cnt_b", {28'b0, cnt_b}, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("postrst_a_valid", {31'b0, bus.a_valid}, 32'd0);
    chk("postrst_b_valid", {31'b0, bus.b_valid}, 32'd0);

`ifdef DEMUX_STREAM_CNT_EN
    // 17 drains of A wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, W'(i + 100), 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    tick();
    chk("cnt_a_wrap", {28'b0, cnt_a}, 32'd1);
    chk("cnt_b_idle", {28'b0, cnt_b}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
